destino_fifos_pausa: RTL

- Receiving end of the arbiter's D0/D1 routing interface.
- Holds two independent destination FIFOs, one per output channel.
- Accepts words pushed by the arbiter and serves them to downstream consumers through pop/empty.
- Generates the D0_pause/D1_pause back-pressure signals that throttle the arbiter before either FIFO overflows.

---
 rtl/destino_fifos_pausa_if.sv | 38 +++
 rtl/destino_fifos_pausa.sv | 131 +++++++++++++
 2 files changed

// File: rtl/destino_fifos_pausa_if.sv
// D0/D1 routing bundle between the arbiter, the destination FIFOs
// and the downstream consumers.
interface destino_fifos_pausa_if #(
    parameter int DATA_WIDTH = 6
);
    logic [DATA_WIDTH-1:0] D0_in;
    logic [DATA_WIDTH-1:0] D1_in;
    logic                  D0_push;
    logic                  D1_push;
    logic                  D0_pop;
    logic                  D1_pop;
    logic [DATA_WIDTH-1:0] D0_out;
    logic [DATA_WIDTH-1:0] D1_out;
    logic                  D0_empty;
    logic                  D1_empty;
    logic                  D0_full;
    logic                  D1_full;
    logic                  D0_almost_empty;
    logic                  D1_almost_empty;
    logic                  D0_pause;
    logic                  D1_pause;
    logic                  D0_error;
    logic                  D1_error;

    modport master (
        output D0_in, D1_in, D0_push, D1_push, D0_pop, D1_pop,
        input  D0_out, D1_out, D0_empty, D1_empty, D0_full, D1_full,
        input  D0_almost_empty, D1_almost_empty,
        input  D0_pause, D1_pause, D0_error, D1_error
    );

    modport slave (
        input  D0_in, D1_in, D0_push, D1_push, D0_pop, D1_pop,
        output D0_out, D1_out, D0_empty, D1_empty, D0_full, D1_full,
        output D0_almost_empty, D1_almost_empty,
        output D0_pause, D1_pause, D0_error, D1_error
    );
endinterface

// File: rtl/destino_fifos_pausa.sv
// Two independent destination FIFOs with registered read data and
// occupancy-based pause back-pressure towards the arbiter.
module destino_fifo_canal #(
    parameter int DATA_WIDTH  = 6,
    parameter int ADDR_WIDTH  = 2,
    parameter int UMBRAL_ALTO = 3,
    parameter int UMBRAL_BAJO = 1
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] d_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] d_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  almost_empty_o,
    output logic                  pause_o,
    output logic                  error_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LLENO = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ALTO  = (ADDR_WIDTH+1)'(UMBRAL_ALTO);
    localparam logic [ADDR_WIDTH:0] BAJO  = (ADDR_WIDTH+1)'(UMBRAL_BAJO);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  err_q, err_d;
    logic                  wr_en, rd_en;

    // Flags decode the registered count only, never push/pop.
    assign empty_o        = (count_q == '0);
    assign full_o         = (count_q == LLENO);
    assign almost_empty_o = (count_q <= BAJO);
    assign pause_o        = (count_q >= ALTO);
    assign error_o        = err_q;
    assign d_o            = out_q;

    always_comb begin
        wr_en    = push_i && (!full_o || pop_i);
        rd_en    = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        out_d    = out_q;
        err_d    = err_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            out_d    = mem_q[rd_ptr_q];
        end
        if (wr_en && !rd_en) count_d = count_q + (ADDR_WIDTH+1)'(1);
        if (rd_en && !wr_en) count_d = count_q - (ADDR_WIDTH+1)'(1);
        if ((push_i && full_o && !pop_i) || (pop_i && empty_o)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= d_i;
    end
endmodule

module destino_fifos_pausa #(
    parameter int DATA_WIDTH  = 6,
    parameter int ADDR_WIDTH  = 2,
    parameter int UMBRAL_ALTO = 3,
    parameter int UMBRAL_BAJO = 1
) (
    input  logic                 clk,
    input  logic                 reset_L,
    destino_fifos_pausa_if.slave bus
);
    destino_fifo_canal #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .UMBRAL_ALTO(UMBRAL_ALTO),
        .UMBRAL_BAJO(UMBRAL_BAJO)
    ) u_d0 (
        .clk           (clk),
        .reset_L       (reset_L),
        .d_i           (bus.D0_in),
        .push_i        (bus.D0_push),
        .pop_i         (bus.D0_pop),
        .d_o           (bus.D0_out),
        .empty_o       (bus.D0_empty),
        .full_o        (bus.D0_full),
        .almost_empty_o(bus.D0_almost_empty),
        .pause_o       (bus.D0_pause),
        .error_o       (bus.D0_error)
    );

    destino_fifo_canal #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .UMBRAL_ALTO(UMBRAL_ALTO),
        .UMBRAL_BAJO(UMBRAL_BAJO)
    ) u_d1 (
        .clk           (clk),
        .reset_L       (reset_L),
        .d_i           (bus.D1_in),
        .push_i        (bus.D1_push),
        .pop_i         (bus.D1_pop),
        .d_o           (bus.D1_out),
        .empty_o       (bus.D1_empty),
        .full_o        (bus.D1_full),
        .almost_empty_o(bus.D1_almost_empty),
        .pause_o       (bus.D1_pause),
        .error_o       (bus.D1_error)
    );
endmodule
